// File: rtl/param_nor_run_detect.sv
// Streaming NOR/AND reducer: counts consecutive matching valid words with a
// saturating counter and flags when the run reaches a programmable threshold.
module param_nor_run_detect #(
    parameter int nbits = 8,
    parameter int cbits = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [nbits-1:0] in_,
    input  logic             in_val,
    input  logic             mode,
    input  logic [cbits-1:0] thresh,
    input  logic             clear,
    output logic             out,
    output logic [cbits-1:0] run_count,
    output logic             detect,
    output logic             detect_pulse
);

    localparam logic [cbits-1:0] cmax = '1;

    logic             match;
    logic             out_next;
    logic [cbits-1:0] count_next;
    logic             pulse_next;

    assign match = mode ? (&in_) : ~(|in_);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        out_next   = out;
        count_next = run_count;
        pulse_next = 1'b0;
        if (clear) begin
            out_next   = 1'b0;
            count_next = '0;
        end else if (in_val) begin
            if (match) begin
                out_next   = 1'b1;
                count_next = (run_count == cmax) ? cmax : run_count + 1'b1;
            end else begin
                out_next   = 1'b0;
                count_next = '0;
            end
            // Pulse only on the crossing edge; saturation or a thresh drop cannot retrigger it.
            pulse_next = match && (thresh != '0) && (run_count < thresh) && (count_next >= thresh);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out          <= 1'b0;
            run_count    <= '0;
            detect_pulse <= 1'b0;
        end else begin
            out          <= out_next;
            run_count    <= count_next;
            detect_pulse <= pulse_next;
        end
    end

    // Live thresh so a threshold change is visible without waiting for an edge.
    assign detect = (thresh != '0) && (run_count >= thresh);

endmodule

// File: tb/tb_param_nor_run_detect.sv
// Self-checking bench for param_nor_run_detect: directed scenarios followed by
// a biased random stream compared against an integer reference model.
module tb_param_nor_run_detect;

    localparam int NB   = 8;
    localparam int CB   = 4;
    localparam int CMAX = (1 << CB) - 1;
    localparam logic [NB-1:0] ONES = {NB{1'b1}};

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NB-1:0] in_;
    logic          in_val;
    logic          mode;
    logic [CB-1:0] thresh;
    logic          clear;
    logic          out;
    logic [CB-1:0] run_count;
    logic          detect;
    logic          detect_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (plain integers)
    int m_cnt   = 0;
    int m_out   = 0;
    int m_pulse = 0;
    int pulse_seen;

    param_nor_run_detect #(.nbits(NB), .cbits(CB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_          (in_),
        .in_val       (in_val),
        .mode         (mode),
        .thresh       (thresh),
        .clear        (clear),
        .out          (out),
        .run_count    (run_count),
        .detect       (detect),
        .detect_pulse (detect_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int exp_det;
        exp_det = (thresh != 0 && m_cnt >= int'(thresh)) ? 1 : 0;
        check({tag, "_out"},   32'(out),          32'(m_out));
        check({tag, "_cnt"},   32'(run_count),    32'(m_cnt));
        check({tag, "_det"},   32'(detect),       32'(exp_det));
        check({tag, "_pulse"}, 32'(detect_pulse), 32'(m_pulse));
    endtask

    // Drive one cycle of inputs, advance the model, then check just after the edge.
    task automatic cycle(input logic [NB-1:0] d, input logic v, input logic md,
                         input logic [CB-1:0] th, input logic c, input string tag);
        int is_match, n_cnt, n_out, n_p;
        in_ = d; in_val = v; mode = md; thresh = th; clear = c;
        is_match = md ? (d == ONES) : (d == '0);
        n_cnt = m_cnt; n_out = m_out; n_p = 0;
        if (c) begin
            n_cnt = 0; n_out = 0;
        end else if (v) begin
            if (is_match != 0) begin
                n_out = 1;
                n_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
                n_p = (th != 0 && m_cnt < int'(th) && n_cnt >= int'(th)) ? 1 : 0;
            end else begin
                n_out = 0; n_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
        m_cnt = n_cnt; m_out = n_out; m_pulse = n_p;
        if (detect_pulse) pulse_seen++;
        check_all(tag);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        m_cnt = 0; m_out = 0; m_pulse = 0;
        check_all(tag);
        in_val = 1'b0; clear = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; in_ = '0; in_val = 1'b0; mode = 1'b0; thresh = 4'd3; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Threshold crossing at 3, then a non-matching word
        for (int i = 0; i < 3; i++) begin
            cycle(8'h00, 1'b1, 1'b0, 4'd3, 1'b0, "cross");
            check("cross_cnt_abs", 32'(run_count), 32'(i + 1));
        end
        check("cross_pulse_abs", 32'(detect_pulse), 32'd1);
        cycle(8'h01, 1'b1, 1'b0, 4'd3, 1'b0, "cross_break");
        check("cross_det_low", 32'(detect), 32'd0);

        // Build a run, then hit it with an asynchronous reset
        cycle(8'h00, 1'b1, 1'b0, 4'd3, 1'b0, "pre_rst");
        cycle(8'h00, 1'b1, 1'b0, 4'd3, 1'b0, "pre_rst");
        do_reset("async_rst");

        // Saturation with gaps in AND mode
        pulse_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(8'hFF, 1'b1, 1'b1, 4'd15, 1'b0, "sat");
            cycle(8'h00, 1'b0, 1'b1, 4'd15, 1'b0, "sat_gap");
        end
        check("sat_cnt_abs", 32'(run_count), 32'd15);
        check("sat_pulse_once", 32'(pulse_seen), 32'd1);

        // thresh = 0 disables detection, raising thresh moves detect immediately
        pulse_seen = 0;
        cycle(8'h00, 1'b0, 1'b0, 4'd0, 1'b1, "th0_clr");
        for (int i = 0; i < 5; i++) cycle(8'h00, 1'b1, 1'b0, 4'd0, 1'b0, "th0");
        check("th0_cnt_abs", 32'(run_count), 32'd5);
        check("th0_det_abs", 32'(detect), 32'd0);
        check("th0_no_pulse", 32'(pulse_seen), 32'd0);
        thresh = 4'd2;
        #1;
        check("th_raise_det", 32'(detect), 32'd1);
        check("th_raise_pulse", 32'(detect_pulse), 32'd0);
        cycle(8'h00, 1'b0, 1'b0, 4'd2, 1'b0, "th_hold");
        check("th_hold_pulse", 32'(detect_pulse), 32'd0);

        // Clear wins over a concurrent valid matching word
        cycle(8'h00, 1'b0, 1'b0, 4'd5, 1'b1, "clr_pre");
        cycle(8'h00, 1'b1, 1'b0, 4'd5, 1'b0, "clr_run");
        cycle(8'h00, 1'b1, 1'b0, 4'd5, 1'b0, "clr_run");
        cycle(8'h00, 1'b1, 1'b0, 4'd5, 1'b1, "clr_hit");
        check("clr_cnt_abs", 32'(run_count), 32'd0);
        check("clr_out_abs", 32'(out), 32'd0);

        // Mode switch mid-run keeps the count
        cycle(8'h00, 1'b1, 1'b0, 4'd5, 1'b0, "mode_run");
        cycle(8'h00, 1'b1, 1'b0, 4'd5, 1'b0, "mode_run");
        cycle(8'hFF, 1'b1, 1'b1, 4'd5, 1'b0, "mode_sw");
        check("mode_cnt_abs", 32'(run_count), 32'd3);

        // Biased random stream
        begin
            logic [NB-1:0] r_in;
            logic          r_mode;
            logic [CB-1:0] r_th;
            r_mode = 1'b0;
            r_th   = 4'd3;
            for (int i = 0; i < 10000; i++) begin
                if ($urandom_range(0, 499) == 0) do_reset("rnd_rst");
                case ($urandom_range(0, 3))
                    0, 1:    r_in = r_mode ? ONES : '0;
                    2:       r_in = r_mode ? '0 : ONES;
                    default: r_in = NB'($urandom);
                endcase
                if ($urandom_range(0, 19) == 0) r_mode = ~r_mode;
                if ($urandom_range(0, 29) == 0)
                    r_th = ($urandom_range(0, 1) != 0) ? CB'($urandom) : CB'($urandom_range(0, 4));
                cycle(r_in, ($urandom_range(0, 3) != 0), r_mode, r_th,
                      ($urandom_range(0, 19) == 0), "rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
